piece_queue: RTL and testbench
==============================

# piece_queue

Next-piece buffer for the Tetris game engine. Sits directly downstream of the random piece generator: it pulses the generator's next-piece request, captures the returned 3-bit piece id, and keeps a FIFO of DEPTH upcoming pieces for the preview display. It hands the active piece to the game engine on spawn and implements the once-per-drop hold slot.

## Interface
- DEPTH, 3: preview FIFO entries (2..6).
- PIECE_W, 3: piece id width. 0 = none; 1..7 = valid pieces.

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- gen_piece  input  PIECE_W  piece id from generator. Registered there, so valid in the cycle after gen_next.
- gen_next  output  PIECE_W-independent 1  one-cycle request pulse to generator
- spawn_req  input  1  engine asks for a new active piece (level)
- hold_req  input  1  engine asks to swap active piece with hold slot (pulse)
- active_piece  output  PIECE_W  current falling piece id
- active_valid  output  1  active_piece meaningful
- spawn_ack  output  1  one-cycle pulse; active_piece changed this cycle
- hold_piece  output  PIECE_W  held piece id, 0 when empty
- hold_lock  output  1  hold already used for this drop
- preview  output  DEPTH*PIECE_W  FIFO contents, slot 0 (next to spawn) in LSBs, empty slots 0
- queue_count  output  3  entries in FIFO (0..DEPTH)

## Operation
- Refill FSM states:
  - IDLE: if queue_count + in-flight < DEPTH, go to REQ.
  - REQ: gen_next=1 for exactly one cycle, then CAP.
  - CAP: sample gen_piece. If it is nonzero, push it. If it is 0, discard it and count no push. Then go to IDLE.
- One piece per 3 cycles at most (IDLE→REQ→CAP). Only one request is ever outstanding.
- Spawn:
  - spawn_req sets a sticky pending flag.
  - When pending and queue_count≥1, pop slot 0 into active_piece, set active_valid, clear hold_lock, pulse spawn_ack, clear pending.
  - An empty FIFO leaves pending set until a push arrives. The pop takes effect the cycle after the push is visible.
- Hold (only when active_valid and !hold_lock):
  - hold_piece==0: active→hold, then pop slot 0 into active. If the FIFO is empty, the hold is refused (no state change).
  - hold_piece≠0: swap active and hold.
  - In either accepted case: set hold_lock and pulse spawn_ack.
  - A hold_req while hold_lock=1 or active_valid=0 is ignored.
- Simultaneous events:
  - spawn pop and CAP push in the same cycle: both apply, queue_count unchanged, pushed entry lands behind shifted entries.
  - spawn_req and hold_req in the same cycle: spawn wins, hold ignored.
  - Push when the FIFO is full: cannot occur (IDLE guard). An assertion flags it.
- FIFO shifts toward slot 0 on pop. Push writes slot queue_count (post-pop index).

## Timing
- Reset (rst=0, asynchronous): every output and internal register is 0.
  - Affects active_piece, active_valid, spawn_ack, hold_piece, hold_lock, preview, queue_count, gen_next, pending flag.
  - FSM goes to IDLE.
- First gen_next occurs one cycle after rst deasserts.
- Full FIFO is reached 3*DEPTH cycles after release (9 for default), given no zero ids.
- Spawn latency: spawn_req sampled at edge N gives active_piece/spawn_ack at edge N+1 when queue_count≥1.
- Hold latency: one cycle, same as spawn.
- Reset asserted mid-REQ/CAP: gen_next drops immediately. The in-flight piece is lost; the generator's own state is not our concern.

## Structure
- Shared package tetris_pkg holds:
  - PIECE_W.
  - PIECE_NONE=3'd0.
  - Piece id constants 3'd1..3'd7, shared with the generator, renderer and collision logic.
  - Refill FSM state enum.
- Sub-module piece_fifo: DEPTH-entry shift-register FIFO with push, pop, same-cycle push+pop, count, and flat parallel peek bus (drives preview).
- Top level keeps refill FSM, spawn pending flag, active/hold registers, lock logic.

## Test plan
- Reset release, generator model returns 5,2,7 → gen_next pulses at cycles 1,4,7. preview = {7,2,5}, queue_count=3 by cycle 9, no further gen_next.
- FIFO {5,2,7} full, spawn_req one cycle → active_piece=5 and spawn_ack next edge. preview={0,7,2} then refill to {x,7,2}, single gen_next issued.
- After reset, spawn_req held high immediately → active_valid stays 0 until first push. active_piece=first id one cycle later, exactly one spawn_ack.
- Active=5, hold empty, FIFO {7,2,...}, hold_req → hold_piece=5, active=2, hold_lock=1. Second hold_req ignored. spawn_req clears hold_lock. Next hold_req swaps active and hold.
- Generator returns 0 once in the sequence 3,0,4 → 0 never enters preview, extra gen_next issued, FIFO ends {…,4,3}.
- rst asserted during CAP with queue_count=2 → all outputs 0 within same cycle. Post-release refill restarts from empty.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris piece ids and the piece_queue refill FSM encoding.
// Latency: none, this file holds only constants and types.
// Backpressure: none.
package tetris_pkg;

    localparam int PIECE_W = 3;

    // Piece ids shared with the generator, renderer and collision logic.
    localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd0;
    localparam logic [PIECE_W-1:0] PIECE_I    = 3'd1;
    localparam logic [PIECE_W-1:0] PIECE_O    = 3'd2;
    localparam logic [PIECE_W-1:0] PIECE_T    = 3'd3;
    localparam logic [PIECE_W-1:0] PIECE_S    = 3'd4;
    localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd5;
    localparam logic [PIECE_W-1:0] PIECE_J    = 3'd6;
    localparam logic [PIECE_W-1:0] PIECE_L    = 3'd7;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_REQ  = 2'd1,
        RF_CAP  = 2'd2
    } refill_state_t;

endpackage

// File: rtl/piece_fifo.sv
// Shift-register FIFO of piece ids with a flat parallel peek of every slot.
// Latency: a push or pop is visible the cycle after the clock edge that takes it.
// Backpressure: none; the caller never pushes into a full FIFO unless it also pops.
//
// Ports: clk, rst (async active-low); push/push_dat write one entry; pop
// shifts every entry one slot toward slot 0; count = entries held;
// peek = all slots, slot 0 in the LSBs, empty slots read 0.
module piece_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [W-1:0]       push_dat,
    input  logic               pop,
    output logic [2:0]         count,
    output logic [DEPTH*W-1:0] peek
);

    logic [W-1:0] slot_q [DEPTH];
    logic [W-1:0] slot_n [DEPTH];
    logic [2:0]   count_n;
    logic [2:0]   wr_idx;
    logic         do_pop;

    assign do_pop = pop && (count != 3'd0);

    always_comb begin
        // The write index is taken after the pop, so a same-cycle push
        // lands directly behind the shifted entries.
        wr_idx = do_pop ? count - 3'd1 : count;
        for (int i = 0; i < DEPTH; i++) begin
            slot_n[i] = slot_q[i];
        end
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slot_n[i] = slot_q[i+1];
            end
            slot_n[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (i == int'(wr_idx))) begin
                slot_n[i] = push_dat;
            end
        end
        count_n = push ? wr_idx + 3'd1 : wr_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count <= 3'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_n[i];
            end
            count <= count_n;
        end
    end

    always_comb begin
        peek = '0;
        for (int i = 0; i < DEPTH; i++) begin
            peek[i*W +: W] = slot_q[i];
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (int'(count) == DEPTH)));

endmodule

// File: rtl/piece_queue.sv
// Next-piece buffer: refills a preview FIFO from the generator, hands out the active piece, runs the hold slot.
// Latency: spawn/hold requests take effect on the second edge after they are raised; refill yields one piece per 3 cycles.
// Backpressure: at most one generator request outstanding; a pending spawn waits until the FIFO holds a piece.
//
// Ports: clk, rst (async active-low); gen_next/gen_piece = generator
// request pulse and the id it returns one cycle later; spawn_req (level,
// sticky), hold_req (pulse) from the engine; active_piece/active_valid,
// spawn_ack, hold_piece/hold_lock, preview (slot 0 in LSBs), queue_count.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int PIECE_W = tetris_pkg::PIECE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIECE_W-1:0]       gen_piece,
    output logic                     gen_next,
    input  logic                     spawn_req,
    input  logic                     hold_req,
    output logic [PIECE_W-1:0]       active_piece,
    output logic                     active_valid,
    output logic                     spawn_ack,
    output logic [PIECE_W-1:0]       hold_piece,
    output logic                     hold_lock,
    output logic [DEPTH*PIECE_W-1:0] preview,
    output logic [2:0]               queue_count
);

    refill_state_t      state_q, state_n;
    logic               cap_push;
    logic               pending_q;
    logic               hold_q;
    logic               spawn_fire;
    logic               hold_fire;
    logic               fifo_pop;
    logic [PIECE_W-1:0] slot0;

    assign slot0 = preview[PIECE_W-1:0];

    // Refill FSM. A request is only in flight while in REQ or CAP, so in
    // IDLE the free-space test needs only the current count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RF_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        gen_next = 1'b0;
        cap_push = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (int'(queue_count) < DEPTH) begin
                    state_n = RF_REQ;
                end
            end
            RF_REQ: begin
                gen_next = 1'b1;
                state_n  = RF_CAP;
            end
            RF_CAP: begin
                // A zero id from the generator is dropped; IDLE will simply ask again.
                cap_push = (gen_piece != PIECE_NONE);
                state_n  = RF_IDLE;
            end
            default: begin
                state_n = RF_IDLE;
            end
        endcase
    end

    // Spawn has priority over hold. An empty-hold request needs a FIFO
    // entry to refill the active slot, otherwise it is refused.
    assign spawn_fire = pending_q && (queue_count != 3'd0);
    assign hold_fire  = hold_q && !spawn_fire && active_valid && !hold_lock &&
                        ((hold_piece != PIECE_NONE) || (queue_count != 3'd0));
    assign fifo_pop   = spawn_fire || (hold_fire && (hold_piece == PIECE_NONE));

    piece_fifo #(
        .DEPTH (DEPTH),
        .W     (PIECE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cap_push),
        .push_dat (gen_piece),
        .pop      (fifo_pop),
        .count    (queue_count),
        .peek     (preview)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q    <= 1'b0;
            hold_q       <= 1'b0;
            active_piece <= '0;
            active_valid <= 1'b0;
            spawn_ack    <= 1'b0;
            hold_piece   <= '0;
            hold_lock    <= 1'b0;
        end else begin
            pending_q <= spawn_fire ? 1'b0 : (pending_q || spawn_req);
            // A hold raised together with a spawn request is dropped.
            hold_q    <= hold_req && !spawn_req;
            spawn_ack <= 1'b0;
            if (spawn_fire) begin
                active_piece <= slot0;
                active_valid <= 1'b1;
                hold_lock    <= 1'b0;
                spawn_ack    <= 1'b1;
            end else if (hold_fire) begin
                if (hold_piece == PIECE_NONE) begin
                    hold_piece   <= active_piece;
                    active_piece <= slot0;
                end else begin
                    hold_piece   <= active_piece;
                    active_piece <= hold_piece;
                end
                hold_lock <= 1'b1;
                spawn_ack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: queue-based model compared every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_piece_queue;

    localparam int DEPTH = 3;
    localparam int PW    = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [PW-1:0]         gen_piece;
    logic                  gen_next;
    logic                  spawn_req;
    logic                  hold_req;
    logic [PW-1:0]         active_piece;
    logic                  active_valid;
    logic                  spawn_ack;
    logic [PW-1:0]         hold_piece;
    logic                  hold_lock;
    logic [DEPTH*PW-1:0]   preview;
    logic [2:0]            queue_count;
    logic [21:0]           dv;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int gn_cnt   = 0;
    int gn_cyc [8];
    int gen_list [$];

    // Model state: the FIFO as a plain queue of ids plus the observable registers.
    int m_q [$];
    int m_phase, m_active, m_hold;
    bit m_valid, m_lock, m_ack, m_pend, m_hreq;

    piece_queue #(
        .DEPTH   (DEPTH),
        .PIECE_W (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gen_piece    (gen_piece),
        .gen_next     (gen_next),
        .spawn_req    (spawn_req),
        .hold_req     (hold_req),
        .active_piece (active_piece),
        .active_valid (active_valid),
        .spawn_ack    (spawn_ack),
        .hold_piece   (hold_piece),
        .hold_lock    (hold_lock),
        .preview      (preview),
        .queue_count  (queue_count)
    );

    assign dv = {gen_next, active_piece, active_valid, spawn_ack,
                 hold_piece, hold_lock, preview, queue_count};

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Generator: registered, so the id appears just after the edge that sees gen_next.
    initial begin
        gen_piece = '0;
        forever begin
            @(posedge clk);
            if (gen_next) begin
                #1;
                if (gen_list.size() > 0) gen_piece = 3'(gen_list.pop_front());
                else gen_piece = 3'd1;
            end
        end
    end

    task automatic model_reset();
        m_q.delete();
        m_phase  = 0;
        m_active = 0;
        m_hold   = 0;
        m_valid  = 0;
        m_lock   = 0;
        m_ack    = 0;
        m_pend   = 0;
        m_hreq   = 0;
        cyc      = 0;
    endtask

    // One clock edge: pops (spawn or hold) first, then the captured push goes to the back.
    task automatic model_step(input bit s_spawn, input bit s_hold, input int g);
        int  pre;
        int  t;
        bit  sp;
        bit  hg;
        pre   = m_q.size();
        m_ack = 0;
        sp = m_pend && (pre > 0);
        hg = !sp && m_hreq && m_valid && !m_lock && ((m_hold != 0) || (pre > 0));
        if (sp) begin
            m_active = m_q.pop_front();
            m_valid  = 1;
            m_lock   = 0;
            m_ack    = 1;
        end else if (hg) begin
            if (m_hold == 0) begin
                m_hold   = m_active;
                m_active = m_q.pop_front();
            end else begin
                t        = m_active;
                m_active = m_hold;
                m_hold   = t;
            end
            m_lock = 1;
            m_ack  = 1;
        end
        if ((m_phase == 2) && (g != 0)) m_q.push_back(g);
        case (m_phase)
            0:       if (pre < DEPTH) m_phase = 1;
            1:       m_phase = 2;
            default: m_phase = 0;
        endcase
        m_pend = sp ? 1'b0 : (m_pend || s_spawn);
        m_hreq = s_hold && !s_spawn;
        cyc++;
    endtask

    function automatic logic [21:0] exp_vec();
        logic [DEPTH*PW-1:0] pv;
        pv = '0;
        for (int i = 0; i < m_q.size(); i++) pv[i*PW +: PW] = 3'(m_q[i]);
        return {(m_phase == 1), 3'(m_active), m_valid, m_ack, 3'(m_hold), m_lock,
                pv, 3'(m_q.size())};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step(spawn_req, hold_req, int'(gen_piece));
        end
    end

    // Per-cycle compare against the model, plus a log of gen_next cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) gn_cnt = 0;
            else if (gen_next) begin
                if (gn_cnt < 8) gn_cyc[gn_cnt] = cyc;
                gn_cnt++;
            end
            check("model", 32'(dv), 32'(exp_vec()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bit got;
        int ack_cyc;
        int acks;
        spawn_req = 0;
        hold_req  = 0;
        got       = 0;
        ack_cyc   = 0;
        acks      = 0;
        repeat (2) @(negedge clk);

        // Fill from reset: requests at 1,4,7, full at 9.
        gen_list = '{5, 2, 7, 4, 3, 6};
        rst = 1;
        repeat (9) @(negedge clk);
        check("fill_preview", 32'(preview), 32'({3'd7, 3'd2, 3'd5}));
        check("fill_count", 32'(queue_count), 32'd3);
        check("gen_cyc0", gn_cyc[0], 32'd1);
        check("gen_cyc1", gn_cyc[1], 32'd4);
        check("gen_cyc2", gn_cyc[2], 32'd7);
        repeat (6) @(negedge clk);
        check("no_extra_req", gn_cnt, 32'd3);

        // Spawn from a full FIFO, then a single refill.
        spawn_req = 1;
        @(negedge clk);
        spawn_req = 0;
        @(negedge clk);
        check("spawn_active", 32'(active_piece), 32'd5);
        check("spawn_ack", 32'(spawn_ack), 32'd1);
        check("spawn_preview", 32'(preview), 32'({3'd0, 3'd7, 3'd2}));
        repeat (6) @(negedge clk);
        check("refill_preview", 32'(preview), 32'({3'd4, 3'd7, 3'd2}));
        check("refill_one_req", gn_cnt, 32'd4);

        // Hold into empty slot, ignored second hold, spawn unlocks, swap.
        hold_req = 1;
        @(negedge clk);
        hold_req = 0;
        @(negedge clk);
        check("hold_piece", 32'(hold_piece), 32'd5);
        check("hold_active", 32'(active_piece), 32'd2);
        check("hold_lock", 32'(hold_lock), 32'd1);
        repeat (2) @(negedge clk);
        hold_req = 1;
        @(negedge clk);
        hold_req = 0;
        repeat (2) @(negedge clk);
        check("hold_ignored_active", 32'(active_piece), 32'd2);
        check("hold_ignored_hold", 32'(hold_piece), 32'd5);
        spawn_req = 1;
        @(negedge clk);
        spawn_req = 0;
        @(negedge clk);
        check("spawn2_active", 32'(active_piece), 32'd7);
        check("spawn2_unlock", 32'(hold_lock), 32'd0);
        hold_req = 1;
        @(negedge clk);
        hold_req = 0;
        @(negedge clk);
        check("swap_active", 32'(active_piece), 32'd5);
        check("swap_hold", 32'(hold_piece), 32'd7);
        check("swap_lock", 32'(hold_lock), 32'd1);

        // Spawn requested from an empty FIFO right out of reset.
        #1 rst = 0;
        @(negedge clk);
        gen_list = '{6, 1, 2};
        rst = 1;
        spawn_req = 1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (cyc == 3) check("valid_before_push", 32'(active_valid), 32'd0);
            if (spawn_ack) begin
                got       = 1;
                ack_cyc   = cyc;
                spawn_req = 0;
            end
        end
        spawn_req = 0;
        check("spawn_wait", 32'(got), 32'd1);
        check("spawn_first_cyc", ack_cyc, 32'd4);
        check("spawn_first_id", 32'(active_piece), 32'd6);
        repeat (10) begin
            @(negedge clk);
            if (spawn_ack) acks++;
        end
        check("single_ack", acks, 32'd0);

        // Zero id from the generator is discarded and re-requested.
        #1 rst = 0;
        @(negedge clk);
        gen_list = '{3, 0, 4, 6};
        rst = 1;
        repeat (9) @(negedge clk);
        check("zero_req_cnt", gn_cnt, 32'd3);
        check("zero_req_cyc", gn_cyc[2], 32'd7);
        check("zero_preview", 32'(preview), 32'({3'd0, 3'd4, 3'd3}));
        check("zero_count", 32'(queue_count), 32'd2);

        // Reset during CAP clears everything at once; refill restarts.
        #1 rst = 0;
        @(negedge clk);
        gen_list = '{1, 2, 3, 6};
        rst = 1;
        repeat (8) @(negedge clk);
        check("cap_count", 32'(queue_count), 32'd2);
        check("cap_no_req", 32'(gen_next), 32'd0);
        #1 rst = 0;
        #1;
        check("async_reset", 32'(dv), 32'd0);
        @(negedge clk);
        gen_list = '{6};
        rst = 1;
        @(negedge clk);
        check("restart_req", 32'(gen_next), 32'd1);
        check("restart_empty", 32'(queue_count), 32'd0);
        repeat (2) @(negedge clk);
        check("restart_count", 32'(queue_count), 32'd1);
        check("restart_preview", 32'(preview), 32'd6);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
